// File: rtl/definitions_pkg.sv
// Shared definitions for the line/window datapath: nominal image width,
// border handling modes and the tap source index helper used by every
// window block.
package definitions_pkg;

  localparam int IMAGE_WIDTH = 8;

  typedef enum logic [1:0] {
    BORDER_REPLICATE = 2'd0,
    BORDER_ZERO      = 2'd1,
    BORDER_MIRROR    = 2'd2
  } border_mode_e;

  // Source index for a tap at line position idx. Positions past the right
  // edge either mirror about the last pixel or clamp to it. Zero mode also
  // clamps here; the caller forces the pixel value to zero instead.
  function automatic int tap_src_idx(input int idx, input int img_w, input logic [1:0] mode);
    int src;
    if (idx <= img_w - 1) begin
      src = idx;
    end else if (mode == BORDER_MIRROR) begin
      src = 2 * (img_w - 1) - idx;
    end else begin
      src = img_w - 1;
    end
    if (src < 0) src = 0;
    return src;
  endfunction

endpackage

// File: rtl/line_window_tap_mux.sv
// One window tap: selects the line pixel at rd_ptr + TAP with right-border
// handling applied.
module line_window_tap_mux
  import definitions_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = IMAGE_WIDTH,
  parameter int PTR_W = 3,
  parameter int TAP   = 0
) (
  input  logic [PIX_W-1:0] line_i [IMG_W],
  input  logic [PTR_W-1:0] rd_ptr_i,
  input  logic [1:0]       border_mode_i,
  output logic [PIX_W-1:0] tap_o
);

  int idx;
  int src;

  // Resolve the source index, then pick the pixel; zero mode blanks taps past the edge.
  always_comb begin
    idx   = int'(rd_ptr_i) + TAP;
    src   = tap_src_idx(idx, IMG_W, border_mode_i);
    tap_o = '0;
    for (int j = 0; j < IMG_W; j++) begin
      if (src == j) tap_o = line_i[j];
    end
    if ((idx > IMG_W - 1) && (border_mode_i == BORDER_ZERO)) tap_o = '0;
  end

endmodule

// File: rtl/line_window_buffer.sv
// Single-line pixel store presenting a KERNEL-pixel horizontal window.
// Flow-controlled write port, window-valid tracking, selectable right border.
// Optional build macro: LINE_WINDOW_ERR_EN enables the sticky o_err flag
// (write while full, or read while the window is not valid).
module line_window_buffer
  import definitions_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = IMAGE_WIDTH,
  parameter int KERNEL = 3
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [PIX_W-1:0]        i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              border_mode,
  input  logic                    rd_enable,
  output logic                    o_valid,
  output logic [KERNEL*PIX_W-1:0] o_data,
  output logic                    o_line_done,
  output logic                    o_err
);

  localparam int PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CNT_W = $clog2(IMG_W + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] CNT_KER  = CNT_W'(KERNEL);

  logic [PIX_W-1:0] line_q [IMG_W];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             line_done_q, line_done_d;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] need;
  logic             wr_acc;
  logic             rd_acc;

  // Handshake and window-valid: the window near the right edge needs only the pixels left in the line.
  always_comb begin
    o_ready = (count_q < CNT_FULL);
    remain  = CNT_FULL - CNT_W'(rd_ptr_q);
    need    = (remain < CNT_KER) ? remain : CNT_KER;
    o_valid = (count_q >= need);
    wr_acc  = i_valid && o_ready;
    rd_acc  = rd_enable && o_valid;
  end

  // Next-state for pointers, occupancy and the line-done pulse.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    line_done_d = 1'b0;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      line_done_d = (rd_ptr_q == PTR_LAST);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      line_done_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      line_done_q <= line_done_d;
    end
  end

  // Pixel array: not reset, only written on an accepted write.
  always_ff @(posedge clk) begin
    if (rstN && wr_acc) line_q[wr_ptr_q] <= i_data;
  end

  assign o_line_done = line_done_q;

`ifdef LINE_WINDOW_ERR_EN
  logic err_q, err_d;

  // Sticky protocol error: write while full or read while the window is incomplete.
  always_comb begin
    err_d = err_q | (i_valid && !o_ready) | (rd_enable && !o_valid);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstN) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Tap 0 lands in the MSBs of o_data.
  for (genvar k = 0; k < KERNEL; k++) begin : g_tap
    line_window_tap_mux #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .PTR_W (PTR_W),
      .TAP   (k)
    ) u_tap (
      .line_i        (line_q),
      .rd_ptr_i      (rd_ptr_q),
      .border_mode_i (border_mode),
      .tap_o         (o_data[(KERNEL-1-k)*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: three instances (8x3, 8x5, 6x3) share one
// stimulus stream and are each checked against a line/window model every cycle.
module tb_line_window_buffer;

  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic [1:0] border_mode = '0;
  logic       rd_enable = 1'b0;

  logic        ordy [ND];
  logic        ovld [ND];
  logic        old  [ND];
  logic        oerr [ND];
  logic [23:0] od0;
  logic [39:0] od1;
  logic [23:0] od2;

  int tests = 0;
  int fails = 0;

  int W [ND];
  int K [ND];
  int mem [ND][8];
  bit wrt [ND][8];
  int wr  [ND];
  int rd  [ND];
  int cnt [ND];
  bit ld  [ND];
  bit er  [ND];

  always #5 clk = ~clk;

  line_window_buffer #(.PIX_W(8), .IMG_W(8), .KERNEL(3)) dut0 (
    .clk(clk), .rstN(rstN), .i_data(i_data), .i_valid(i_valid), .o_ready(ordy[0]),
    .border_mode(border_mode), .rd_enable(rd_enable), .o_valid(ovld[0]),
    .o_data(od0), .o_line_done(old[0]), .o_err(oerr[0]));

  line_window_buffer #(.PIX_W(8), .IMG_W(8), .KERNEL(5)) dut1 (
    .clk(clk), .rstN(rstN), .i_data(i_data), .i_valid(i_valid), .o_ready(ordy[1]),
    .border_mode(border_mode), .rd_enable(rd_enable), .o_valid(ovld[1]),
    .o_data(od1), .o_line_done(old[1]), .o_err(oerr[1]));

  line_window_buffer #(.PIX_W(8), .IMG_W(6), .KERNEL(3)) dut2 (
    .clk(clk), .rstN(rstN), .i_data(i_data), .i_valid(i_valid), .o_ready(ordy[2]),
    .border_mode(border_mode), .rd_enable(rd_enable), .o_valid(ovld[2]),
    .o_data(od2), .o_line_done(old[2]), .o_err(oerr[2]));

  function automatic logic [63:0] get_od(input int d);
    if (d == 0)      return {40'b0, od0};
    else if (d == 1) return {24'b0, od1};
    else             return {40'b0, od2};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected window from the border rules; def clears if any source pixel was never written.
  task automatic model_window(input int d, input int mode, output logic [63:0] v, output bit def);
    int idx, src, pix;
    v = '0;
    def = 1'b1;
    for (int t = 0; t < K[d]; t++) begin
      idx = rd[d] + t;
      if (idx < W[d]) begin
        pix = mem[d][idx];
        def &= wrt[d][idx];
      end else if (mode == 1) begin
        pix = 0;
      end else begin
        src = (mode == 2) ? 2 * (W[d] - 1) - idx : W[d] - 1;
        pix = mem[d][src];
        def &= wrt[d][src];
      end
      v = (v << 8) | 64'(pix);
    end
  endtask

  task automatic model_update(input int d, input bit iv, input int dat, input bit re, input bit rn);
    bit ready, valid, wa, ra;
    int need;
    if (!rn) begin
      wr[d] = 0; rd[d] = 0; cnt[d] = 0; ld[d] = 0; er[d] = 0;
      return;
    end
    ready = cnt[d] < W[d];
    need  = (W[d] - rd[d] < K[d]) ? W[d] - rd[d] : K[d];
    valid = cnt[d] >= need;
    wa = iv && ready;
    ra = re && valid;
    if ((iv && !ready) || (re && !valid)) er[d] = 1'b1;
    if (wa) begin
      mem[d][wr[d]] = dat;
      wrt[d][wr[d]] = 1'b1;
      wr[d] = (wr[d] + 1) % W[d];
    end
    ld[d] = ra && (rd[d] == W[d] - 1);
    if (ra) rd[d] = (rd[d] + 1) % W[d];
    cnt[d] = cnt[d] + (wa ? 1 : 0) - (ra ? 1 : 0);
  endtask

  task automatic check_dut(input int d, input int mode);
    logic [63:0] v;
    bit def;
    int need;
    need = (W[d] - rd[d] < K[d]) ? W[d] - rd[d] : K[d];
    check($sformatf("d%0d_ready", d), {63'b0, ordy[d]}, {63'b0, cnt[d] < W[d]});
    check($sformatf("d%0d_valid", d), {63'b0, ovld[d]}, {63'b0, cnt[d] >= need});
    check($sformatf("d%0d_line_done", d), {63'b0, old[d]}, {63'b0, ld[d]});
`ifdef LINE_WINDOW_ERR_EN
    check($sformatf("d%0d_err", d), {63'b0, oerr[d]}, {63'b0, er[d]});
`else
    check($sformatf("d%0d_err", d), {63'b0, oerr[d]}, 64'd0);
`endif
    model_window(d, mode, v, def);
    if (def) check($sformatf("d%0d_data_rd%0d", d, rd[d]), get_od(d), v);
  endtask

  task automatic step(input bit iv, input int dat, input bit re, input int mode, input bit rn);
    i_valid     = iv;
    i_data      = dat[7:0];
    rd_enable   = re;
    border_mode = mode[1:0];
    rstN        = rn;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) model_update(d, iv, dat, re, rn);
    for (int d = 0; d < ND; d++) check_dut(d, mode);
  endtask

  function automatic logic [63:0] rep_win(input int r);
    logic [63:0] v = '0;
    for (int t = 0; t < 3; t++) v = (v << 8) | 64'(((10 + r + t) > 17) ? 17 : (10 + r + t));
    return v;
  endfunction

  initial begin
    int mode;
    W[0] = 8; K[0] = 3;
    W[1] = 8; K[1] = 5;
    W[2] = 6; K[2] = 3;
    for (int d = 0; d < ND; d++) begin
      for (int j = 0; j < 8; j++) begin mem[d][j] = 0; wrt[d][j] = 1'b0; end
      wr[d] = 0; rd[d] = 0; cnt[d] = 0; ld[d] = 0; er[d] = 0;
    end

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_ready", {63'b0, ordy[0]}, 64'd1);
    check("rst_valid", {63'b0, ovld[0]}, 64'd0);
    check("rst_line_done", {63'b0, old[0]}, 64'd0);
    check("rst_err", {63'b0, oerr[0]}, 64'd0);

    // Replicate: write 10..17, read the whole line
    for (int p = 10; p <= 17; p++) step(1, p, 0, 0, 1);
    for (int r = 0; r < 8; r++) begin
      check($sformatf("rep_win%0d", r), get_od(0), rep_win(r));
      step(0, 0, 1, 0, 1);
      check($sformatf("rep_done%0d", r), {63'b0, old[0]}, (r == 7) ? 64'd1 : 64'd0);
    end
    step(0, 0, 0, 0, 1);
    check("rep_done_once", {63'b0, old[0]}, 64'd0);

    // Mirror and zero borders on the last two windows
    step(0, 0, 0, 0, 0);
    for (int p = 10; p <= 17; p++) step(1, p, 0, 0, 1);
    for (int r = 0; r < 6; r++) step(0, 0, 1, 0, 1);
    step(0, 0, 0, 2, 1);
    check("mirror_rd6", get_od(0), 64'h101110);
    step(0, 0, 0, 1, 1);
    check("zero_rd6", get_od(0), 64'h101100);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 2, 1);
    check("mirror_rd7", get_od(0), 64'h11100F);
    step(0, 0, 0, 1, 1);
    check("zero_rd7", get_od(0), 64'h110000);

    // KERNEL=5 valid threshold; reads while not valid are ignored
    step(0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) step(1, 32 + p, 0, 0, 1);
    check("k5_valid_3", {63'b0, ovld[1]}, 64'd0);
    step(0, 0, 1, 0, 1);
    step(1, 35, 0, 0, 1);
    check("k5_valid_4", {63'b0, ovld[1]}, 64'd0);
    step(1, 36, 0, 0, 1);
    check("k5_valid_5", {63'b0, ovld[1]}, 64'd1);
    check("k5_rdptr0", get_od(1), 64'h2021222324);

    // Full behaviour: drop when full, simultaneous write+read at full and at count 4
    step(0, 0, 0, 0, 0);
    for (int p = 0; p < 8; p++) step(1, 64 + p, 0, 0, 1);
    check("full_ready", {63'b0, ordy[0]}, 64'd0);
    step(1, 8'h99, 0, 0, 1);
    step(1, 8'h98, 1, 0, 1);
    check("full_wr_rd_ready", {63'b0, ordy[0]}, 64'd1);
    for (int r = 0; r < 3; r++) step(0, 0, 1, 0, 1);
    step(1, 8'h77, 1, 0, 1);
    for (int r = 0; r < 3; r++) step(0, 0, 1, 0, 1);
    check("cnt4_drained", {63'b0, ovld[0]}, 64'd0);

    // Mid-line reset discards the partial line
    for (int p = 0; p < 3; p++) step(1, 80 + p, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("midrst_ready", {63'b0, ordy[0]}, 64'd1);
    check("midrst_valid", {63'b0, ovld[0]}, 64'd0);

`ifdef LINE_WINDOW_ERR_EN
    for (int p = 0; p < 9; p++) step(1, 90 + p, 0, 0, 1);
    check("err_set", {63'b0, oerr[0]}, 64'd1);
    for (int p = 0; p < 3; p++) step(0, 0, 0, 0, 1);
    check("err_sticky", {63'b0, oerr[0]}, 64'd1);
    step(0, 0, 0, 0, 0);
    check("err_clr", {63'b0, oerr[0]}, 64'd0);
`endif

    // Randomized streaming across several lines, border mode changed per frame
    step(0, 0, 0, 0, 0);
    mode = int'($urandom_range(0, 3));
    for (int c = 0; c < 800; c++) begin
      if (c % 160 == 0) mode = int'($urandom_range(0, 3));
      step(($urandom % 4) != 0, int'($urandom_range(0, 255)), ($urandom % 3) != 0, mode, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
